fmap_window_gen: RTL and testbench



---
 rtl/cnn_pkg.sv | 25 ++
 rtl/fmap_line_buffer.sv | 49 ++++
 rtl/fmap_window_gen.sv | 138 +++++++++++++
 tb/tb_fmap_window_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN feature-map front end.
// The derived sizes describe the default 28x28 frame with a 5x5 kernel.
package cnn_pkg;

  localparam int CNN_I_F_BW = 8;
  localparam int CNN_IX     = 28;
  localparam int CNN_IY     = 28;
  localparam int CNN_KX     = 5;
  localparam int CNN_KY     = 5;

  localparam int CNN_OX    = CNN_IX - CNN_KX + 1;
  localparam int CNN_OY    = CNN_IY - CNN_KY + 1;
  localparam int CNN_WIN_W = CNN_KX * CNN_KY * CNN_I_F_BW;

  // Line-buffer storage style: addressed RAM or a plain shift register.
  typedef enum logic [0:0] {
    LB_RAM   = 1'b0,
    LB_SHIFT = 1'b1
  } lb_impl_e;

  function automatic int win_bits(input int kx, input int ky, input int bw);
    return kx * ky * bw;
  endfunction

endpackage

// File: rtl/fmap_line_buffer.sv
// One raster line of delay: returns the pixel accepted DEPTH beats ago.
// The old entry is read before the new pixel overwrites it on an enabled edge.
module fmap_line_buffer
  import cnn_pkg::*;
#(
  parameter int       DEPTH = CNN_IX,
  parameter int       WIDTH = CNN_I_F_BW,
  parameter lb_impl_e IMPL  = LB_RAM,
  localparam int      AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  generate
    if (IMPL == LB_RAM) begin : g_ram
      logic [WIDTH-1:0] mem_q [DEPTH];

      always_ff @(posedge clk_i) begin
        if (en_i) begin
          mem_q[addr_i] <= data_i;
        end
      end

      assign data_o = mem_q[addr_i];
    end else begin : g_shift
      // The column counter walks every address in order, so a DEPTH-long
      // shift register delivers the same old entry without using the address.
      logic [WIDTH-1:0] sr_q [DEPTH];
      logic             unused_addr;

      always_ff @(posedge clk_i) begin
        if (en_i) begin
          sr_q[0] <= data_i;
          for (int i = 1; i < DEPTH; i++) begin
            sr_q[i] <= sr_q[i-1];
          end
        end
      end

      assign data_o      = sr_q[DEPTH-1];
      assign unused_addr = ^addr_i;
    end
  endgenerate

endmodule

// File: rtl/fmap_window_gen.sv
// Sliding KXxKY window generator over a raster pixel stream.
// KY-1 cascaded line buffers feed the right column of a register window.
module fmap_window_gen
  import cnn_pkg::*;
#(
  parameter int       I_F_BW  = CNN_I_F_BW,
  parameter int       IX      = CNN_IX,
  parameter int       IY      = CNN_IY,
  parameter int       KX      = CNN_KX,
  parameter int       KY      = CNN_KY,
  parameter lb_impl_e LB_IMPL = LB_RAM
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_in_valid,
  input  logic [I_F_BW-1:0]          i_pixel,
  output logic [KX*KY*I_F_BW-1:0]    o_window,
  output logic                       o_ot_valid,
  output logic                       o_frame_done
);

  localparam int CW    = $clog2(IX);
  localparam int RW    = $clog2(IY);
  localparam int WIN_W = win_bits(KX, KY, I_F_BW);

  localparam logic [CW-1:0] COL_LAST      = CW'(IX - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(KX - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IY - 1);
  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(KY - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  logic [I_F_BW-1:0] lb_in   [KY-1];
  logic [I_F_BW-1:0] lb_out  [KY-1];
  logic [I_F_BW-1:0] col_new [KY];
  logic [I_F_BW-1:0] win_q   [KY][KX];
  logic [I_F_BW-1:0] win_d   [KY][KX];

  // Raster position of the pixel offered this cycle; moves only on accepted beats.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (i_in_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < KY - 1; k++) begin : g_lb
      if (k == 0) begin : g_head
        assign lb_in[k] = i_pixel;
      end else begin : g_tail
        assign lb_in[k] = lb_out[k-1];
      end

      fmap_line_buffer #(
        .DEPTH (IX),
        .WIDTH (I_F_BW),
        .IMPL  (LB_IMPL)
      ) u_line_buffer (
        .clk_i  (clk),
        .en_i   (i_in_valid),
        .addr_i (col_q),
        .data_i (lb_in[k]),
        .data_o (lb_out[k])
      );

      // The deepest buffer holds the oldest line, which lands in the top row.
      assign col_new[KY-2-k] = lb_out[k];
    end
  endgenerate

  assign col_new[KY-1] = i_pixel;

  always_comb begin
    win_d = win_q;
    if (i_in_valid) begin
      for (int r = 0; r < KY; r++) begin
        for (int c = 0; c < KX - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][KX-1] = col_new[r];
      end
    end
  end

  // Valid/done are single-cycle pulses, one clock after the accepted pixel that
  // completes a window; there is no ready, so each pulse must be taken as seen.
  always_comb begin
    valid_d = i_in_valid && (row_q >= ROW_FIRST_WIN) && (col_q >= COL_FIRST_WIN);
    done_d  = i_in_valid && (row_q == ROW_LAST) && (col_q == COL_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int r = 0; r < KY; r++) begin
        for (int c = 0; c < KX; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    o_window = '0;
    for (int r = 0; r < KY; r++) begin
      for (int c = 0; c < KX; c++) begin
        o_window[(r*KX+c)*I_F_BW +: I_F_BW] = win_q[r][c];
      end
    end
  end

  assign o_ot_valid   = valid_q;
  assign o_frame_done = done_q;

  logic unused_win_w;
  assign unused_win_w = (WIN_W == KX * KY * I_F_BW);

endmodule

// File: tb/tb_fmap_window_gen.sv
// Directed bench for fmap_window_gen: ramp/constant frames, gaps, back-to-back
// frames and mid-frame reset, checked against a window scoreboard.
module tb_fmap_window_gen;
  import cnn_pkg::*;

  localparam int BW    = CNN_I_F_BW;
  localparam int IX    = CNN_IX;
  localparam int IY    = CNN_IY;
  localparam int KX    = CNN_KX;
  localparam int KY    = CNN_KY;
  localparam int WIN_W = CNN_WIN_W;
  localparam int N_WIN = CNN_OX * CNN_OY;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_in_valid;
  logic [BW-1:0]    i_pixel;
  logic [WIN_W-1:0] o_window;
  logic             o_ot_valid;
  logic             o_frame_done;

  fmap_window_gen dut (
    .clk          (clk),
    .reset        (reset),
    .i_in_valid   (i_in_valid),
    .i_pixel      (i_pixel),
    .o_window     (o_window),
    .o_ot_valid   (o_ot_valid),
    .o_frame_done (o_frame_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIN_W:0] exp_q[$];

  int   acc_cnt  = 0;
  logic acc_prev = 1'b0;
  logic rst_prev = 1'b1;

  always @(posedge clk) begin
    acc_cnt  <= acc_cnt + ((i_in_valid && !reset) ? 1 : 0);
    acc_prev <= i_in_valid && !reset;
    rst_prev <= reset;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] pix(input int mode, input int y, input int x);
    case (mode)
      0:       return BW'((y * IX + x) % 256);
      1:       return '0;
      default: return '1;
    endcase
  endfunction

  function automatic logic [WIN_W-1:0] exp_win(input int mode, input int y, input int x);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int r = 0; r < KY; r++) begin
      for (int c = 0; c < KX; c++) begin
        w[(r*KX+c)*BW +: BW] = pix(mode, y - KY + 1 + r, x - KX + 1 + c);
      end
    end
    return w;
  endfunction

  // scoreboard / monitor
  logic             mon_en   = 1'b0;
  int               valid_cnt = 0;
  int               done_cnt  = 0;
  int               arm       = 0;
  int               seen_arm  = 0;
  int               first_acc = 0;
  logic [WIN_W-1:0] first_win;
  logic [WIN_W-1:0] last_done_win;
  logic [WIN_W-1:0] prev_win;
  logic [WIN_W:0]   exp_e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (o_ot_valid) begin
        valid_cnt++;
        if (seen_arm != arm) begin
          first_acc = acc_cnt;
          first_win = o_window;
          seen_arm  = arm;
        end
        check("valid_after_accept", 256'(acc_prev), 256'(1));
        check("window_expected", 256'(exp_q.size() != 0), 256'(1));
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          check("window", 256'(o_window), 256'(exp_e[WIN_W-1:0]));
          check("frame_done", 256'(o_frame_done), 256'(exp_e[WIN_W]));
        end
      end else begin
        check("done_without_valid", 256'(o_frame_done), 256'(0));
      end
      if (!acc_prev && !rst_prev) begin
        check("hold_on_gap", 256'(o_window), 256'(prev_win));
      end
      if (o_frame_done) begin
        done_cnt++;
        last_done_win = o_window;
      end
    end
    prev_win = o_window;
  end

  // driver tasks
  task automatic drive(input logic v, input logic [BW-1:0] p, input logic r);
    @(posedge clk);
    #1;
    i_in_valid = v;
    i_pixel    = p;
    reset      = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, BW'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic send_frame(input int mode, input bit gaps, input int npix);
    int y, x;
    for (int idx = 0; idx < npix; idx++) begin
      y = idx / IX;
      x = idx % IX;
      if (gaps) begin
        for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
          drive(1'b0, BW'($urandom_range(0, 255)), 1'b0);
        end
      end
      drive(1'b1, pix(mode, y, x), 1'b0);
      if (y >= KY - 1 && x >= KX - 1) begin
        exp_q.push_back({(y == IY - 1 && x == IX - 1), exp_win(mode, y, x)});
      end
    end
  endtask

  int base_acc, base_valid, base_done;

  task automatic begin_test();
    idle(3);
    base_acc   = acc_cnt;
    base_valid = valid_cnt;
    base_done  = done_cnt;
    arm++;
  endtask

  task automatic end_test(input string tag, input int nwin, input int ndone);
    idle(3);
    check({tag, "_valid_count"}, 256'(valid_cnt - base_valid), 256'(nwin));
    check({tag, "_done_count"}, 256'(done_cnt - base_done), 256'(ndone));
    check({tag, "_queue_drained"}, 256'(exp_q.size()), 256'(0));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_window"}, 256'(o_window), 256'(0));
    check({tag, "_valid"}, 256'(o_ot_valid), 256'(0));
    check({tag, "_done"}, 256'(o_frame_done), 256'(0));
  endtask

  initial begin
    reset      = 1'b1;
    i_in_valid = 1'b0;
    i_pixel    = '0;
    repeat (3) @(posedge clk);
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    check_zero("reset");
    mon_en = 1'b1;

    // Ramp frame, valid every cycle.
    begin_test();
    send_frame(0, 1'b0, IX * IY);
    end_test("ramp", N_WIN, 1);
    check("ramp_first_latency", 256'(first_acc - base_acc), 256'(117));
    check("ramp_first_e00", 256'(first_win[0 +: BW]), 256'(0));
    check("ramp_first_e04", 256'(first_win[32 +: BW]), 256'(4));
    check("ramp_first_e40", 256'(first_win[160 +: BW]), 256'(112));
    check("ramp_first_e44", 256'(first_win[192 +: BW]), 256'(116));
    check("ramp_last_e44", 256'(last_done_win[192 +: BW]), 256'(15));

    // Same ramp with random input gaps.
    begin_test();
    send_frame(0, 1'b1, IX * IY);
    end_test("gaps", N_WIN, 1);
    check("gaps_first_latency", 256'(first_acc - base_acc), 256'(117));
    check("gaps_last_e44", 256'(last_done_win[192 +: BW]), 256'(15));

    // Two frames back to back.
    begin_test();
    send_frame(0, 1'b0, IX * IY);
    send_frame(0, 1'b0, IX * IY);
    end_test("b2b", 2 * N_WIN, 2);

    // Reset after 300 pixels, then a full frame.
    begin_test();
    send_frame(0, 1'b0, 300);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    check_zero("mid_reset");
    check("mid_reset_partial_windows", 256'(valid_cnt - base_valid), 256'(160));
    check("mid_reset_queue", 256'(exp_q.size()), 256'(0));
    begin_test();
    send_frame(0, 1'b0, IX * IY);
    end_test("post_reset", N_WIN, 1);
    check("post_reset_first_latency", 256'(first_acc - base_acc), 256'(117));

    // Zero frame then 0xFF frame.
    begin_test();
    send_frame(1, 1'b0, IX * IY);
    send_frame(2, 1'b0, IX * IY);
    end_test("const", 2 * N_WIN, 2);
    check("const_last_window", 256'(last_done_win), 256'({WIN_W{1'b1}}));

    // Reset held while pixels are offered.
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) drive(1'b1, BW'($urandom_range(0, 255)), 1'b1);
      else        drive(1'b0, '0, 1'b0);
      if (i > 0) begin
        @(negedge clk);
        check_zero("held_reset");
      end
    end
    begin_test();
    send_frame(0, 1'b0, IX * IY);
    end_test("after_held", N_WIN, 1);
    check("after_held_first_latency", 256'(first_acc - base_acc), 256'(117));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
